// File: rtl/multi_axis_tracker_pkg.sv
// Shared definitions for the multi-axis step tracker: per-axis FSM states
// and the default tuning values used by the top-level parameters.
package multi_axis_tracker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MOVE_POS = 2'd1,
      ST_MOVE_NEG = 2'd2,
      ST_DWELL    = 2'd3
   } axis_state_t;

   localparam int DEF_DEADBAND    = 2;
   localparam int DEF_STEP_DIV    = 1000;
   localparam int DEF_DWELL_TICKS = 4;

endpackage

// File: rtl/track_axis.sv
// One tracking axis: signed error from the held sample, the IDLE / MOVE /
// DWELL state machine, its dwell counter and the registered step pulses.
module track_axis
   import multi_axis_tracker_pkg::*;
#(
   parameter int W           = 16,
   parameter int DEADBAND    = DEF_DEADBAND,
   parameter int DWELL_TICKS = DEF_DWELL_TICKS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_tick,
   input  logic         i_mode_auto,
   input  logic         i_mode_chg,
   input  logic [W-1:0] i_sens_a,
   input  logic [W-1:0] i_sens_b,
   input  logic [W-1:0] i_target,
   input  logic [W-1:0] i_actual,
   output logic         o_out_pos,
   output logic         o_out_neg,
   output logic         o_at_target
);

   // Counter is sized so it can always hold DWELL_TICKS, even when that is 0.
   localparam int DW = $clog2(DWELL_TICKS + 2);

   // One extra bit so a full-scale difference of two W-bit words never wraps.
   localparam logic signed [W:0] LP_DB  = (W+1)'(DEADBAND);
   localparam logic signed [W:0] LP_NDB = -LP_DB;

   axis_state_t          r_state;
   axis_state_t          w_state_nxt;
   logic [DW-1:0]        r_dwell;
   logic signed [W:0]    w_err;
   logic                 w_above;
   logic                 w_below;
   logic                 w_in_band;
   logic                 r_out_pos;
   logic                 r_out_neg;
   logic                 r_at_target;

   assign w_err     = i_mode_auto ? ({1'b0, i_sens_a} - {1'b0, i_sens_b})
                                  : ({1'b0, i_target} - {1'b0, i_actual});
   assign w_above   = (w_err > LP_DB);
   assign w_below   = (w_err < LP_NDB);
   assign w_in_band = !w_above && !w_below;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic; a mode change abandons any move via DWELL.
   // NOTE: the default assignment first keeps every path driven, so no latch
   // is inferred when a case arm leaves the state unchanged.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_above)      w_state_nxt = ST_MOVE_POS;
            else if (w_below) w_state_nxt = ST_MOVE_NEG;
         end
         ST_MOVE_POS: begin
            if (i_mode_chg || !w_above) w_state_nxt = ST_DWELL;
         end
         ST_MOVE_NEG: begin
            if (i_mode_chg || !w_below) w_state_nxt = ST_DWELL;
         end
         ST_DWELL: begin
            if (i_tick && (r_dwell <= DW'(1))) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Dwell counter: load on entry to DWELL, count down one per tick inside it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dwell <= '0;
      end else if ((r_state != ST_DWELL) && (w_state_nxt == ST_DWELL)) begin
         r_dwell <= DW'(DWELL_TICKS);
      end else if ((r_state == ST_DWELL) && i_tick && (r_dwell != '0)) begin
         r_dwell <= r_dwell - DW'(1);
      end
   end

   // Step pulses and settled flag, registered one cycle behind the tick.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_pos   <= 1'b0;
         r_out_neg   <= 1'b0;
         r_at_target <= 1'b0;
      end else begin
         r_out_pos   <= i_tick && !i_mode_chg && (r_state == ST_MOVE_POS);
         r_out_neg   <= i_tick && !i_mode_chg && (r_state == ST_MOVE_NEG);
         r_at_target <= (r_state == ST_IDLE) && w_in_band;
      end
   end

   assign o_out_pos   = r_out_pos;
   assign o_out_neg   = r_out_neg;
   assign o_at_target = r_at_target;

endmodule

// File: rtl/multi_axis_tracker.sv
// Multi-axis step tracker: holds the last strobed sample, runs the shared
// step-rate prescaler and instantiates one track_axis per axis.
module multi_axis_tracker
   import multi_axis_tracker_pkg::*;
#(
   parameter int N_AXES      = 2,
   parameter int W           = 16,
   parameter int DEADBAND    = DEF_DEADBAND,
   parameter int STEP_DIV    = DEF_STEP_DIV,
   parameter int DWELL_TICKS = DEF_DWELL_TICKS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode_auto,
   input  logic                  sample_valid,
   input  logic [N_AXES*W-1:0]   sens_a,
   input  logic [N_AXES*W-1:0]   sens_b,
   input  logic [N_AXES*W-1:0]   target,
   input  logic [N_AXES*W-1:0]   actual,
   output logic [N_AXES-1:0]     out_pos,
   output logic [N_AXES-1:0]     out_neg,
   output logic [N_AXES-1:0]     at_target
);

   localparam int PW = $clog2(STEP_DIV);

   logic [N_AXES*W-1:0] r_sens_a;
   logic [N_AXES*W-1:0] r_sens_b;
   logic [N_AXES*W-1:0] r_target;
   logic [N_AXES*W-1:0] r_actual;
   logic                r_mode_auto;
   logic                r_mode_d;
   logic                w_mode_chg;
   logic [PW-1:0]       r_presc;
   logic                w_tick;
   logic [N_AXES-1:0]   w_out_pos;
   logic [N_AXES-1:0]   w_out_neg;
   logic [N_AXES-1:0]   w_at_target;

   // Held sample: captured on the strobe, otherwise kept.
   // NOTE: these data registers get an explicit reset because the axes read
   // them straight after reset; bulk storage that is written before it is
   // read would normally be left without one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sens_a    <= '0;
         r_sens_b    <= '0;
         r_target    <= '0;
         r_actual    <= '0;
         r_mode_auto <= 1'b0;
      end else if (sample_valid) begin
         r_sens_a    <= sens_a;
         r_sens_b    <= sens_b;
         r_target    <= target;
         r_actual    <= actual;
         r_mode_auto <= mode_auto;
      end
   end

   // Delayed copy of the held mode, flagging the one cycle after it changes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_mode_d <= 1'b0;
      else      r_mode_d <= r_mode_auto;
   end

   assign w_mode_chg = r_mode_auto ^ r_mode_d;

   // Shared prescaler counting 0..STEP_DIV-1; tick is its terminal count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + PW'(1);
   end

   assign w_tick = (r_presc == PW'(STEP_DIV - 1));

   for (genvar g = 0; g < N_AXES; g++) begin : gen_axis
      track_axis #(
         .W           (W),
         .DEADBAND    (DEADBAND),
         .DWELL_TICKS (DWELL_TICKS)
      ) u_axis (
         .clk         (clk),
         .rst         (rst),
         .i_tick      (w_tick),
         .i_mode_auto (r_mode_auto),
         .i_mode_chg  (w_mode_chg),
         .i_sens_a    (r_sens_a[g*W +: W]),
         .i_sens_b    (r_sens_b[g*W +: W]),
         .i_target    (r_target[g*W +: W]),
         .i_actual    (r_actual[g*W +: W]),
         .o_out_pos   (w_out_pos[g]),
         .o_out_neg   (w_out_neg[g]),
         .o_at_target (w_at_target[g])
      );
   end

   assign out_pos   = w_out_pos;
   assign out_neg   = w_out_neg;
   assign at_target = w_at_target;

endmodule

// File: tb/tb_multi_axis_tracker.sv
// Bench for multi_axis_tracker: directed samples at fixed cycles, expected
// step pulses (cycle and direction) queued per axis, and a negedge monitor
// that pops and compares every pulse the DUT emits.
module tb_multi_axis_tracker;

   localparam int N  = 2;
   localparam int W  = 16;
   localparam int SD = 4;
   localparam int DB = 2;
   localparam int DT = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            mode_auto;
   logic            sample_valid;
   logic [N*W-1:0]  sens_a;
   logic [N*W-1:0]  sens_b;
   logic [N*W-1:0]  target;
   logic [N*W-1:0]  actual;
   logic [N-1:0]    out_pos;
   logic [N-1:0]    out_neg;
   logic [N-1:0]    at_target;

   typedef struct {
      int cyc;
      bit pos;
   } pulse_t;

   pulse_t exp_q0[$];
   pulse_t exp_q1[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   multi_axis_tracker #(
      .N_AXES      (N),
      .W           (W),
      .DEADBAND    (DB),
      .STEP_DIV    (SD),
      .DWELL_TICKS (DT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mode_auto    (mode_auto),
      .sample_valid (sample_valid),
      .sens_a       (sens_a),
      .sens_b       (sens_b),
      .target       (target),
      .actual       (actual),
      .out_pos      (out_pos),
      .out_neg      (out_neg),
      .at_target    (at_target)
   );

   // Edges since reset release; the first edge after release is cycle 1.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int ax, input int c, input bit p);
      pulse_t e;
      e.cyc = c;
      e.pos = p;
      if (ax == 0) exp_q0.push_back(e);
      else         exp_q1.push_back(e);
   endtask

   // Monitor: every pulse must match the head of its axis queue.
   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (out_pos[i] || out_neg[i]) begin
            pulse_t e;
            bit     have;
            check($sformatf("exclusive_ax%0d", i), {31'b0, out_pos[i] & out_neg[i]}, 32'd0);
            have = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
            if (!have) begin
               check($sformatf("unexpected_pulse_ax%0d", i), cyc, 32'hFFFF_FFFF);
            end else begin
               e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
               check($sformatf("pulse_cycle_ax%0d", i), cyc, e.cyc);
               check($sformatf("pulse_dir_ax%0d", i), {31'b0, out_pos[i]}, {31'b0, e.pos});
            end
         end
      end
   end

   // Advance to #1 after edge n.
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
      check("goto_cycle", cyc, n);
   endtask

   // Scramble the data inputs so only the held sample can matter.
   task automatic scramble();
      logic [31:0] rnd;
      rnd       = $urandom;
      mode_auto = rnd[0];
      sens_a    = $urandom;
      sens_b    = $urandom;
      target    = $urandom;
      actual    = $urandom;
   endtask

   // Present a sample so that it is latched on edge s.
   task automatic sample_at(input int s, input logic m, input logic [31:0] sa,
                            input logic [31:0] sb, input logic [31:0] tg,
                            input logic [31:0] ac);
      goto(s - 1);
      mode_auto    = m;
      sens_a       = sa;
      sens_b       = sb;
      target       = tg;
      actual       = ac;
      sample_valid = 1'b1;
      goto(s);
      sample_valid = 1'b0;
      scramble();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [31:0] rnd;
      // Reset with random inputs: every output must stay low.
      rst          = 1'b0;
      sample_valid = 1'b0;
      scramble();
      repeat (3) begin
         @(posedge clk);
         #1;
         rnd          = $urandom;
         sample_valid = rnd[1];
         scramble();
         check("rst_out_pos", {30'b0, out_pos}, 32'd0);
         check("rst_out_neg", {30'b0, out_neg}, 32'd0);
         check("rst_at_target", {30'b0, at_target}, 32'd0);
      end

      // Manual forward on axis 0 (err +15), sampled on the first edge after
      // release: first tick on cycle 3, so first pulse visible on cycle 4.
      rst          = 1'b1;
      mode_auto    = 1'b0;
      sens_a       = '0;
      sens_b       = '0;
      target       = {16'd0, 16'd30};
      actual       = {16'd0, 16'd15};
      sample_valid = 1'b1;
      push_exp(0, 4, 1'b1);
      push_exp(0, 8, 1'b1);
      goto(1);
      sample_valid = 1'b0;
      scramble();
      goto(5);
      check("fwd_at_target0_moving", {31'b0, at_target[0]}, 32'd0);
      check("fwd_at_target1_idle", {31'b0, at_target[1]}, 32'd1);
      // actual=28 -> err +2 (in band): DWELL from 9, ticks 11 and 15, IDLE at 16.
      sample_at(8, 1'b0, 32'd0, 32'd0, {16'd0, 16'd30}, {16'd0, 16'd28});
      goto(14);
      check("fwd_at_target0_dwell", {31'b0, at_target[0]}, 32'd0);
      goto(17);
      check("fwd_at_target0_settled", {31'b0, at_target[0]}, 32'd1);

      // Deadband edges on axis 0: +3 moves, -2 stops and settles, -3 moves back.
      sample_at(20, 1'b0, 32'd0, 32'd0, {16'd0, 16'd100}, {16'd0, 16'd97});
      push_exp(0, 24, 1'b1);
      push_exp(0, 28, 1'b1);
      goto(25);
      check("db_plus3_moving", {31'b0, at_target[0]}, 32'd0);
      sample_at(28, 1'b0, 32'd0, 32'd0, {16'd0, 16'd100}, {16'd0, 16'd102});
      goto(38);
      check("db_minus2_settled", {31'b0, at_target[0]}, 32'd1);
      sample_at(40, 1'b0, 32'd0, 32'd0, {16'd0, 16'd100}, {16'd0, 16'd103});
      push_exp(0, 44, 1'b0);
      sample_at(44, 1'b0, 32'd0, 32'd0, {16'd0, 16'd100}, {16'd0, 16'd100});
      goto(53);
      check("db_zero_settled", {31'b0, at_target[0]}, 32'd1);

      // Auto reversal on axis 1: err -10 then +20, through two silent ticks.
      sample_at(56, 1'b1, {16'd35, 16'd0}, {16'd45, 16'd0}, 32'd0, 32'd0);
      push_exp(1, 60, 1'b0);
      push_exp(1, 64, 1'b0);
      goto(61);
      check("rev_at_target1_moving", {31'b0, at_target[1]}, 32'd0);
      sample_at(64, 1'b1, {16'd60, 16'd0}, {16'd40, 16'd0}, 32'd0, 32'd0);
      push_exp(1, 76, 1'b1);
      push_exp(1, 80, 1'b1);
      goto(70);
      check("rev_at_target1_dwell", {31'b0, at_target[1]}, 32'd0);
      sample_at(80, 1'b1, {16'd50, 16'd0}, {16'd50, 16'd0}, 32'd0, 32'd0);
      goto(89);
      check("rev_at_target1_settled", {31'b0, at_target[1]}, 32'd1);

      // Mode switch mid-move: axis 0 moving positive in auto; the manual
      // sample lands in a tick cycle, so the pulse due on 100 is dropped.
      sample_at(92, 1'b1, {16'd0, 16'd200}, {16'd0, 16'd100}, 32'd0, 32'd0);
      push_exp(0, 96, 1'b1);
      sample_at(99, 1'b0, 32'd0, 32'd0, {16'd0, 16'd50}, {16'd0, 16'd60});
      push_exp(0, 112, 1'b0);
      goto(104);
      check("mode_sw_dwell", {31'b0, at_target[0]}, 32'd0);
      sample_at(112, 1'b0, 32'd0, 32'd0, {16'd0, 16'd50}, {16'd0, 16'd50});
      goto(121);
      check("mode_sw_settled", {31'b0, at_target[0]}, 32'd1);

      // Full-scale errors in both directions, then reset during a pulse.
      sample_at(124, 1'b1, {16'h0000, 16'hFFFF}, {16'hFFFF, 16'h0000}, 32'd0, 32'd0);
      push_exp(0, 128, 1'b1);
      push_exp(1, 128, 1'b0);
      goto(132);
      check("ext_out_pos_due", {30'b0, out_pos}, 32'd1);
      check("ext_out_neg_due", {30'b0, out_neg}, 32'd2);
      rst = 1'b0;
      #1;
      check("midrst_out_pos", {30'b0, out_pos}, 32'd0);
      check("midrst_out_neg", {30'b0, out_neg}, 32'd0);
      check("midrst_at_target", {30'b0, at_target}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_out_pos", {30'b0, out_pos}, 32'd0);
      check("rst_hold_out_neg", {30'b0, out_neg}, 32'd0);
      check("q0_drained", exp_q0.size(), 32'd0);
      check("q1_drained", exp_q1.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
